// File: rtl/attn_mh_tile_ctrl.sv
// Multi-head, row-tiled scaled-dot-product attention sequencer.
// Drives a shared SA (Q.K^T, then P.V) and an external softmax unit row by row.
module attn_mh_tile_ctrl #(
  parameter int unsigned D_W         = 16,
  parameter int unsigned SA_N        = 16,
  parameter int unsigned HEADS       = 2,
  parameter int unsigned Q_TILES     = 2,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic                            I_CLK,
  input  logic                            I_ASYN_RST,
  input  logic                            I_START,
  input  logic                            I_ABORT,
  input  logic [HEADS*Q_TILES*SA_N*SA_N*D_W-1:0] I_MAT_Q,
  input  logic [HEADS*SA_N*SA_N*D_W-1:0]  I_MAT_K,
  input  logic [HEADS*SA_N*SA_N*D_W-1:0]  I_MAT_V,
  input  logic                            I_SA_VLD,
  input  logic [SA_N*SA_N*D_W-1:0]        I_SA_RESULT,
  input  logic                            I_SM_VLD,
  input  logic [SA_N*D_W-1:0]             I_SM_DATA,
  output logic                            O_SA_START,
  output logic                            O_SA_CLEARN,
  output logic [SA_N*SA_N*D_W-1:0]        O_MAT_1,
  output logic [SA_N*SA_N*D_W-1:0]        O_MAT_2,
  output logic                            O_SM_START,
  output logic [SA_N*D_W-1:0]             O_SM_DATA,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic [HEADS*Q_TILES*SA_N*SA_N*D_W-1:0] O_ATT_DATA
);

  localparam int unsigned SEQ = Q_TILES * SA_N;
  localparam int unsigned MW  = SA_N * SA_N * D_W;
  localparam int unsigned RW  = SA_N * D_W;
  localparam int unsigned HW  = (HEADS > 1) ? $clog2(HEADS) : 1;
  localparam int unsigned TW  = (Q_TILES > 1) ? $clog2(Q_TILES) : 1;
  localparam int unsigned RCW = (SA_N > 1) ? $clog2(SA_N) : 1;

  typedef enum logic [3:0] {
    StIdle, StClrQk, StStQk, StWaitQk, StSmIssue, StSmWait,
    StClrPv, StStPv, StWaitPv, StNext, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  h_q, h_d;
  logic [TW-1:0]  t_q, t_d;
  logic [RCW-1:0] r_q, r_d;
  logic           abort_q, abort_d;
  logic           ld_qk, cap_s, sm_wr, ld_v, att_wr;
  logic [MW-1:0]  mat1_q, mat2_q;
  logic [HEADS*SEQ*RW-1:0] att_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    t_d     = t_q;
    r_d     = r_q;
    abort_d = 1'b0;
    ld_qk   = 1'b0;
    cap_s   = 1'b0;
    sm_wr   = 1'b0;
    ld_v    = 1'b0;
    att_wr  = 1'b0;
    if (state_q != StIdle && I_ABORT) begin
      state_d = StIdle;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: if (I_START) begin
          h_d     = '0;
          t_d     = '0;
          ld_qk   = 1'b1;
          state_d = StClrQk;
        end
        StClrQk:  state_d = StStQk;
        StStQk:   state_d = StWaitQk;
        StWaitQk: if (I_SA_VLD) begin
          cap_s   = 1'b1;
          r_d     = '0;
          state_d = StSmIssue;
        end
        StSmIssue: state_d = StSmWait;
        StSmWait: if (I_SM_VLD) begin
          sm_wr = 1'b1;
          if (r_q == RCW'(SA_N - 1)) begin
            ld_v    = 1'b1;
            state_d = StClrPv;
          end else begin
            r_d     = r_q + 1'b1;
            state_d = StSmIssue;
          end
        end
        StClrPv:  state_d = StStPv;
        StStPv:   state_d = StWaitPv;
        StWaitPv: if (I_SA_VLD) begin
          att_wr  = 1'b1;
          state_d = StNext;
        end
        StNext: begin
          if (t_q != TW'(Q_TILES - 1)) begin
            t_d     = t_q + 1'b1;
            ld_qk   = 1'b1;
            state_d = StClrQk;
          end else if (h_q != HW'(HEADS - 1)) begin
            t_d     = '0;
            h_d     = h_q + 1'b1;
            ld_qk   = 1'b1;
            state_d = StClrQk;
          end else begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state_q <= StIdle;
      h_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      t_q     <= t_d;
      r_q     <= r_d;
      abort_q <= abort_d;
    end
  end

  // Operands are loaded on entry to CLR_QK using the next head/tile indices.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      mat1_q <= '0;
      mat2_q <= '0;
      att_q  <= '0;
    end else begin
      if (ld_qk) begin
        for (int unsigned i = 0; i < SA_N; i++) begin
          for (int unsigned c = 0; c < SA_N; c++) begin
            mat1_q[(i*SA_N + c)*D_W +: D_W] <=
                I_MAT_Q[((32'(h_d)*SEQ + 32'(t_d)*SA_N + i)*SA_N + c)*D_W +: D_W];
            mat2_q[(c*SA_N + i)*D_W +: D_W] <=
                I_MAT_K[((32'(h_d)*SA_N + i)*SA_N + c)*D_W +: D_W];
          end
        end
      end
      if (cap_s) begin
        for (int unsigned e = 0; e < SA_N*SA_N; e++) begin
          mat1_q[e*D_W +: D_W] <= $signed(I_SA_RESULT[e*D_W +: D_W]) >>> SCALE_SHIFT;
        end
      end
      if (sm_wr) mat1_q[32'(r_q)*RW +: RW] <= I_SM_DATA;
      if (ld_v)  mat2_q <= I_MAT_V[32'(h_q)*MW +: MW];
      if (att_wr) att_q[(32'(h_q)*SEQ + 32'(t_q)*SA_N)*RW +: MW] <= I_SA_RESULT;
    end
  end

  // abort_q holds the SA clear low for the single cycle after an abort.
  assign O_SA_CLEARN = !(state_q == StClrQk || state_q == StClrPv || abort_q);
  assign O_SA_START  = (state_q == StStQk) || (state_q == StStPv);
  assign O_SM_START  = (state_q == StSmIssue);
  assign O_BUSY      = (state_q != StIdle);
  assign O_DONE      = (state_q == StDone);
  assign O_MAT_1     = mat1_q;
  assign O_MAT_2     = mat2_q;
  assign O_SM_DATA   = mat1_q[32'(r_q)*RW +: RW];
  assign O_ATT_DATA  = att_q;

endmodule
